// File: rtl/sr_framer.sv
// Frame synchroniser for the parallel window of a serial shift register.
// Hunts for SYNC_WORD, then locks and emits aligned payload words.
module sr_framer #(
    parameter int                 WIDTH         = 4,
    parameter logic [WIDTH-1:0]   SYNC_WORD     = 4'b1011,
    parameter int                 PAYLOAD_WORDS = 2,
    parameter int                 MISS_LIMIT    = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [WIDTH-1:0]                       word_in,
    output logic                                   locked,
    output logic [WIDTH-1:0]                       data_out,
    output logic                                   data_valid,
    output logic                                   sync_lost,
    output logic [$clog2(PAYLOAD_WORDS+1)-1:0]     word_index
);

    localparam int BW = $clog2(WIDTH);
    localparam int WW = $clog2(PAYLOAD_WORDS + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [WW-1:0] SYNC_SLOT = WW'(PAYLOAD_WORDS);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [WW-1:0]    word_cnt_q, word_cnt_d;
    logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
    logic [WIDTH-1:0] data_q,     data_d;
    logic [WW-1:0]    index_q,    index_d;
    logic             valid_q,    valid_d;
    logic             lost_q,     lost_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_d     = data_q;
        index_d    = index_q;
        valid_d    = 1'b0;
        lost_d     = 1'b0;

        if (enable) begin
            case (state_q)
                HUNT: begin
                    if (word_in == SYNC_WORD) begin
                        state_d    = LOCKED;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        miss_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < SYNC_SLOT) begin
                            data_d     = word_in;
                            index_d    = word_cnt_q;
                            valid_d    = 1'b1;
                            word_cnt_d = word_cnt_q + 1'b1;
                        end else begin
                            // Sync slot: a miss below the limit keeps the current alignment.
                            word_cnt_d = '0;
                            if (word_in == SYNC_WORD) begin
                                miss_cnt_d = '0;
                            end else if (miss_cnt_q < MISS_LAST) begin
                                miss_cnt_d = miss_cnt_q + 1'b1;
                            end else begin
                                state_d    = HUNT;
                                lost_d     = 1'b1;
                                miss_cnt_d = '0;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            miss_cnt_q <= '0;
            data_q     <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            data_q     <= data_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            lost_q     <= lost_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign sync_lost  = lost_q;
    assign word_index = index_q;

endmodule

// File: tb/tb_sr_framer.sv
// Testbench for sr_framer: a left-shifting serial register feeds the framer,
// and expected payload captures are queued as each word is transmitted.
module tb_sr_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       serialBit;
    logic [3:0] srQ;
    logic [3:0] word_in;
    logic       locked;
    logic [3:0] data_out;
    logic       data_valid;
    logic       sync_lost;
    logic [1:0] word_index;

    typedef struct {
        logic [3:0] data;
        logic [1:0] idx;
        int         edgeNo;
    } exp_t;

    exp_t expQ[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   edgeCnt     = 0;
    int   lostEdge    = -1;

    sr_framer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .word_in    (word_in),
        .locked     (locked),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync_lost  (sync_lost),
        .word_index (word_index)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      srQ <= 4'b0000;
        else if (enable) srQ <= {srQ[2:0], serialBit};
    end
    assign word_in = srQ;

    // Every valid strobe must match the oldest queued capture, including the edge it lands on.
    always @(posedge clk) begin
        edgeCnt++;
        #1;
        if (reset === 1'b1) begin
            vectors++;
            assert (sync_lost === logic'(edgeCnt == lostEdge)) else begin
                miscompares++;
                $error("FAIL syncLost edge=%0d observed=%b expected=%b", edgeCnt, sync_lost, edgeCnt == lostEdge);
            end
            if (data_valid === 1'b1) begin
                vectors++;
                assert (expQ.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpectedValid edge=%0d observed data=%h idx=%0d expected no strobe", edgeCnt, data_out, word_index);
                end
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    assert (data_out === e.data && word_index === e.idx && edgeCnt == e.edgeNo) else begin
                        miscompares++;
                        $error("FAIL capture observed data=%h idx=%0d edge=%0d expected data=%h idx=%0d edge=%0d",
                               data_out, word_index, edgeCnt, e.data, e.idx, e.edgeNo);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic en);
        @(negedge clk);
        serialBit = b;
        enable    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) applyStimulus(w[i], 1'b1);
    endtask

    task automatic pushExp(input logic [3:0] w, input logic [1:0] idx, input int offset);
        exp_t x;
        x.data   = w;
        x.idx    = idx;
        x.edgeNo = edgeCnt + offset;
        expQ.push_back(x);
    endtask

    task automatic sendPayload(input logic [3:0] w, input logic [1:0] idx);
        pushExp(w, idx, 5);
        sendWord(w);
    endtask

    initial begin
        logic [3:0] steady [6];
        steady = '{4'h3, 4'h9, 4'hE, 4'h1, 4'h5, 4'hA};
        reset     = 1'b0;
        enable    = 1'b0;
        serialBit = 1'b0;
        #12;
        checkOutput("rstLocked", locked, 0);
        checkOutput("rstData", data_out, 0);
        checkOutput("rstValid", data_valid, 0);
        checkOutput("rstLost", sync_lost, 0);
        checkOutput("rstIndex", word_index, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Lock and first frame.
        sendWord(4'b1011);
        checkOutput("preLock", locked, 0);
        pushExp(4'b0110, 2'd0, 5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lockEdge", locked, 1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        sendPayload(4'b1100, 2'd1);

        // Steady frames.
        for (int f = 0; f < 3; f++) begin
            sendWord(4'b1011);
            sendPayload(steady[2*f], 2'd0);
            sendPayload(steady[2*f+1], 2'd1);
            checkOutput("steadyLocked", locked, 1);
        end

        // Single miss is absorbed, then a good sync clears the miss count.
        sendWord(4'b1111);
        sendPayload(4'h2, 2'd0);
        sendPayload(4'hD, 2'd1);
        checkOutput("flywheelLocked", locked, 1);
        sendWord(4'b1011);
        sendPayload(4'h4, 2'd0);
        sendPayload(4'h7, 2'd1);

        // Two consecutive misses drop lock.
        sendWord(4'b1111);
        sendPayload(4'h8, 2'd0);
        sendPayload(4'hC, 2'd1);
        checkOutput("oneMissLocked", locked, 1);
        lostEdge = edgeCnt + 5;
        sendWord(4'b1111);
        applyStimulus(1'b0, 1'b1);
        checkOutput("dropLocked", locked, 0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("huntLocked", locked, 0);

        // Relock; payloads equal to the sync word are plain data.
        sendWord(4'b1011);
        checkOutput("preRelock", locked, 0);
        pushExp(4'b1011, 2'd0, 5);
        applyStimulus(1'b1, 1'b1);
        checkOutput("relock", locked, 1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        sendPayload(4'b0110, 2'd1);
        sendWord(4'b1011);
        sendPayload(4'h1, 2'd0);
        sendPayload(4'b1011, 2'd1);
        sendWord(4'b1011);
        sendPayload(4'h2, 2'd0);
        sendPayload(4'h6, 2'd1);
        checkOutput("syncPayloadLocked", locked, 1);

        // Enable gap in the middle of a payload word.
        sendWord(4'b1011);
        pushExp(4'b1001, 2'd0, 8);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        sendPayload(4'h5, 2'd1);

        // Reset mid-frame, then a fresh sync is needed.
        sendWord(4'b1011);
        sendPayload(4'hE, 2'd0);
        sendPayload(4'h7, 2'd1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("preRstData", data_out, 4'h7);
        checkOutput("preRstIndex", word_index, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstLocked", locked, 0);
        checkOutput("midRstData", data_out, 0);
        checkOutput("midRstIndex", word_index, 0);
        checkOutput("midRstValid", data_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sendWord(4'b1011);
        checkOutput("postRstHunt", locked, 0);
        pushExp(4'h3, 2'd0, 5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("postRstLock", locked, 1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        sendPayload(4'hC, 2'd1);
        sendWord(4'b1011);
        repeat (3) applyStimulus(1'b0, 1'b0);

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
